pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter register plus next-PC selection for the MIPS core; successor of the flat NPC mux.
//  Evaluates six branch conditions, j/jal and jr redirects, and stalls.
//  Holds a redirect resolved during a stall until release.
//  Counts taken redirects and flags misaligned jr targets.
//  Sits between the controller/GRF read ports and IM address input.
// PARAMETERS
//  ADDR_W    32            PC width; legal range 29..32
//  RESET_PC  32'h0000_3000 PC value after reset (word aligned)
//  CNT_W     16            width of saturating redirect counter
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  stall        in   1       1 = hold PC this cycle
//  branch       in   1       current instr is a conditional branch
//  br_cond      in   3       condition code (see BEHAVIOUR)
//  cmp_a        in   32      rs value
//  cmp_b        in   32      rt value
//  imm16        in   16      branch offset, in words
//  jump         in   2       00 none, 01 j/jal, 10 jr, 11 reserved (= none)
//  instr_index  in   26      j/jal target field
//  jr_target    in   ADDR_W  jr register value
//  pc_out       out  ADDR_W  current PC to IM
//  pc_plus4     out  ADDR_W  pc_out+4, mod 2^ADDR_W; feeds the jal link value
//  taken        out  1       combinational: current inputs resolve a redirect
//  redirect_cnt out  CNT_W   count of PC loads from a redirect target
//  addr_err     out  1       sticky misaligned-jr flag
// BEHAVIOUR
//  Reset (clk edge with reset=1): pc_out=RESET_PC, pend_v=0, redirect_cnt=0, addr_err=0. Reset overrides stall and pend.
//  br_cond: 000 EQ a==b, 001 NE a!=b, 010 LEZ a<=0, 011 GTZ a>0, 100 LTZ a<0, 101 GEZ a>=0.
//   Signed compares against zero; codes 110/111 are never true.
//  Targets:
//   br_tgt = pc_plus4 + (sext(imm16)<<2), mod 2^ADDR_W.
//   j_tgt  = {pc_plus4[ADDR_W-1:28], instr_index, 2'b00}.
//   jr_tgt = {jr_target[ADDR_W-1:2], 2'b00}.
//  Priority: jump 01/10 > (branch & cond) > sequential.
//   taken = (jump==01)|(jump==10)|(branch&cond).
//  State: pend_v (1b), pend_tgt (ADDR_W). Two states, RUN (pend_v=0) and HELD (pend_v=1).
//  RUN:
//   stall=0: PC <= taken ? target : pc_plus4.
//   stall=1: PC holds. If taken: pend_v<=1, pend_tgt<=target -> HELD.
//  HELD:
//   stall=1: PC holds; new inputs ignored; the first latched target is kept.
//   stall=0: PC <= pend_tgt, pend_v<=0 -> RUN. Current-cycle inputs are ignored; they are the same resolved instruction.
//  redirect_cnt: +1 on every edge where PC loads a redirect target (RUN taken&~stall, or HELD release).
//   Saturates at all-ones. Latch into pend does not count.
//  addr_err: set on the edge where PC loads a jr target and jr_target[1:0]!=0.
//   Also set on a HELD release whose latched jr target was misaligned. Cleared only by reset.
//  Wrap: PC 0xFFFF_FFFC + 4 -> 0x0000_0000, no flag.
//  Latency: target visible on pc_out one cycle after inputs are presented.
// STRUCTURE
//  npc_pkg: BR_EQ..BR_GEZ codes, JMP_NONE/JMP_J/JMP_JR codes, RESET_PC default.
//  Sub-module br_cond_eval (combinational): cmp_a, cmp_b, br_cond -> cond.
//  All state lives in pc_sequencer.
// TESTING
//  1 Reset, stall=0, no branch/jump, 3 cycles -> pc_out 3000,3004,3008,300C.
//  2 At PC 3010: branch=1, EQ, a=b=5, imm16=16'hFFFC -> next PC 3004, taken=1, cnt=1.
//    Same with NE -> 3014, cnt unchanged.
//  3 GTZ, a=32'h8000_0000 -> not taken. LEZ, a=0 -> taken.
//    GEZ, a=0 -> taken. LTZ, a=-1 -> taken.
//  4 At PC 3020: jump=01, idx=26'h0000C40 -> 0000_3100. Then jump=10, jr_target=3202 -> PC 3200, addr_err=1 and stays 1.
//  5 At PC 3040: stall=1 for 3 cycles with j to 3400 in cycle 1, inputs zeroed in cycles 2-3 -> PC holds 3040.
//    Release -> 3400, cnt +1 once.
//  6 Reset asserted while HELD -> PC=3000, pend cleared, cnt=0. Saturation: CNT_W=2, 5 redirects -> cnt=3.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared encodings for the program-counter sequencer:
//   - branch condition codes (br_cond input)
//   - jump kind codes (jump input)
//   - default reset PC
//   - two-state sequencer FSM type (RUN / HELD)
// No ports; imported by pc_sequencer and br_cond_eval.
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LEZ = 3'b010;
    localparam logic [2:0] BR_GTZ = 3'b011;
    localparam logic [2:0] BR_LTZ = 3'b100;
    localparam logic [2:0] BR_GEZ = 3'b101;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // RUN: no redirect pending. HELD: a redirect resolved under stall is parked.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HELD = 1'b1
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_br_cond_eval.sv
// -----------------------------------------------------------------------------
// br_cond_eval
// Purely combinational branch-condition evaluator.
// Ports:
//   i_cmp_a   [31:0] rs value (treated as signed for zero compares)
//   i_cmp_b   [31:0] rt value (used by EQ/NE only)
//   i_br_cond [2:0]  condition code, see pc_sequencer_pkg
//   o_cond           1 when the selected condition holds; codes 110/111 never hold
// -----------------------------------------------------------------------------
module br_cond_eval
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] i_cmp_a,
    input  logic [31:0] i_cmp_b,
    input  logic [2:0]  i_br_cond,
    output logic        o_cond
);

    logic signed [31:0] w_a_s;

    assign w_a_s = $signed(i_cmp_a);

    always_comb begin
        o_cond = 1'b0;
        case (i_br_cond)
            BR_EQ:   o_cond = (i_cmp_a == i_cmp_b);
            BR_NE:   o_cond = (i_cmp_a != i_cmp_b);
            BR_LEZ:  o_cond = (w_a_s <= 32'sd0);
            BR_GTZ:  o_cond = (w_a_s >  32'sd0);
            BR_LTZ:  o_cond = (w_a_s <  32'sd0);
            BR_GEZ:  o_cond = (w_a_s >= 32'sd0);
            default: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter register and next-PC selection for the MIPS core.
// Resolves conditional branches, j/jal and jr redirects, honours stalls and
// parks a redirect that resolves during a stall until the stall releases.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   stall        1 = hold PC this cycle
//   branch       current instruction is a conditional branch
//   br_cond[2:0] branch condition code
//   cmp_a[31:0]  rs value
//   cmp_b[31:0]  rt value
//   imm16[15:0]  branch offset in words
//   jump[1:0]    00 none, 01 j/jal, 10 jr, 11 treated as none
//   instr_index  j/jal target field (26 bits)
//   jr_target    jr register value (ADDR_W bits)
//   pc_out       current PC to instruction memory
//   pc_plus4     pc_out + 4 (wraps), jal link value
//   taken        combinational: current inputs resolve a redirect
//   redirect_cnt saturating count of PC loads from a redirect target
//   addr_err     sticky flag: a misaligned jr target was loaded into the PC
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0],
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic [2:0]        br_cond,
    input  logic [31:0]       cmp_a,
    input  logic [31:0]       cmp_b,
    input  logic [15:0]       imm16,
    input  logic [1:0]        jump,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              taken,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pend_tgt;
    logic              r_pend_misal;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_j_tgt;
    logic [ADDR_W-1:0] w_jr_tgt;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_cond;
    logic              w_is_j;
    logic              w_is_jr;
    logic              w_taken;
    logic              w_tgt_misal;
    logic              w_pend_ld;
    logic              w_cnt_inc;
    logic              w_err_set;

    br_cond_eval u_br_cond_eval (
        .i_cmp_a   (cmp_a),
        .i_cmp_b   (cmp_b),
        .i_br_cond (br_cond),
        .o_cond    (w_cond)
    );

    // Candidate targets, all computed every cycle; the priority mux picks one.
    assign w_pc_plus4 = r_pc + PC_STEP;
    assign w_br_off   = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign w_br_tgt   = w_pc_plus4 + w_br_off;
    assign w_j_tgt    = {w_pc_plus4[ADDR_W-1:28], instr_index, 2'b00};
    assign w_jr_tgt   = {jr_target[ADDR_W-1:2], 2'b00};

    // jump code 11 falls through to "no jump".
    assign w_is_j  = (jump == JMP_J);
    assign w_is_jr = (jump == JMP_JR);
    assign w_taken = w_is_j | w_is_jr | (branch & w_cond);

    always_comb begin
        w_target = w_pc_plus4;
        if (w_is_j) begin
            w_target = w_j_tgt;
        end else if (w_is_jr) begin
            w_target = w_jr_tgt;
        end else if (branch & w_cond) begin
            w_target = w_br_tgt;
        end
    end

    // jr outranks branches, so a selected jr always supplies the target.
    assign w_tgt_misal = w_is_jr & (jr_target[1:0] != 2'b00);

    // Next-state / next-PC decision
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_ld   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    w_pc_nxt  = w_taken ? w_target : w_pc_plus4;
                    w_cnt_inc = w_taken;
                    w_err_set = w_taken & w_tgt_misal;
                end else if (w_taken) begin
                    w_pend_ld   = 1'b1;
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                // Inputs present at release belong to the already-resolved
                // instruction, so only the parked target matters.
                if (!stall) begin
                    w_pc_nxt    = r_pend_tgt;
                    w_cnt_inc   = 1'b1;
                    w_err_set   = r_pend_misal;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_cnt_inc) begin
                r_cnt <= sat_inc(r_cnt);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Parked target: only meaningful while HELD, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_pend_ld) begin
            r_pend_tgt   <= w_target;
            r_pend_misal <= w_tgt_misal;
        end
    end

    assign pc_out       = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign taken        = w_taken;
    assign redirect_cnt = r_cnt;
    assign addr_err     = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// traffic, compared every cycle against a behavioural model. A second instance
// with a 2-bit counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [2:0]  br_cond;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [15:0] imm16;
    logic [1:0]  jump;
    logic [25:0] instr_index;
    logic [31:0] jr_target;

    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        taken;
    logic [15:0] redirect_cnt;
    logic        addr_err;

    logic [31:0] pc_out2;
    logic [31:0] pc_plus4_2;
    logic        taken2;
    logic [1:0]  redirect_cnt2;
    logic        addr_err2;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit [31:0] m_pc;
    bit        m_pend_v;
    bit [31:0] m_pend_tgt;
    bit        m_pend_bad;
    int        m_cnt;
    int        m_cnt2;
    bit        m_err;

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_3000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .br_cond(br_cond), .cmp_a(cmp_a), .cmp_b(cmp_b), .imm16(imm16),
        .jump(jump), .instr_index(instr_index), .jr_target(jr_target),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .taken(taken),
        .redirect_cnt(redirect_cnt), .addr_err(addr_err)
    );

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_3000), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .br_cond(br_cond), .cmp_a(cmp_a), .cmp_b(cmp_b), .imm16(imm16),
        .jump(jump), .instr_index(instr_index), .jr_target(jr_target),
        .pc_out(pc_out2), .pc_plus4(pc_plus4_2), .taken(taken2),
        .redirect_cnt(redirect_cnt2), .addr_err(addr_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_cond(bit [2:0] c, bit [31:0] a, bit [31:0] b);
        int sa;
        sa = int'(a);
        case (c)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return sa <= 0;
            3'd3:    return sa > 0;
            3'd4:    return sa < 0;
            3'd5:    return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat(int v, int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // One clock: check taken before the edge, advance model on the edge,
    // check registered outputs just after it. Returns at the next negedge.
    task automatic tick();
        bit        tk;
        bit        bad;
        bit [31:0] p4;
        bit [31:0] tgt;
        int        off;
        #1;
        p4  = m_pc + 32'd4;
        off = int'($signed(imm16));
        bad = 1'b0;
        if (jump == 2'b01) begin
            tk  = 1'b1;
            tgt = {p4[31:28], instr_index, 2'b00};
        end else if (jump == 2'b10) begin
            tk  = 1'b1;
            tgt = jr_target & 32'hFFFF_FFFC;
            bad = (jr_target % 4) != 0;
        end else if (branch && model_cond(br_cond, cmp_a, cmp_b)) begin
            tk  = 1'b1;
            tgt = p4 + 32'(off * 4);
        end else begin
            tk  = 1'b0;
            tgt = p4;
        end
        check("taken", 32'(taken), 32'(tk));
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0000_3000; m_pend_v = 0; m_cnt = 0; m_cnt2 = 0; m_err = 0;
        end else if (m_pend_v) begin
            if (!stall) begin
                m_pc = m_pend_tgt; m_pend_v = 0;
                m_cnt = sat(m_cnt, 65535); m_cnt2 = sat(m_cnt2, 3);
                if (m_pend_bad) m_err = 1;
            end
        end else if (!stall) begin
            m_pc = tgt;
            if (tk) begin
                m_cnt = sat(m_cnt, 65535); m_cnt2 = sat(m_cnt2, 3);
                if (bad) m_err = 1;
            end
        end else if (tk) begin
            m_pend_v = 1; m_pend_tgt = tgt; m_pend_bad = bad;
        end
        #1;
        check("pc_out", pc_out, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("redirect_cnt", 32'(redirect_cnt), 32'(m_cnt));
        check("addr_err", 32'(addr_err), 32'(m_err));
        check("redirect_cnt_w2", 32'(redirect_cnt2), 32'(m_cnt2));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; branch = 0; br_cond = 0; cmp_a = 0; cmp_b = 0;
        imm16 = 0; jump = 0; instr_index = 0; jr_target = 0;
    endtask

    initial begin
        m_pc = 0; m_pend_v = 0; m_pend_tgt = 0; m_pend_bad = 0;
        m_cnt = 0; m_cnt2 = 0; m_err = 0;
        reset = 1;
        idle_inputs();
        @(negedge clk);

        // Reset and sequential fetch
        tick();
        check("rst_pc", pc_out, 32'h3000);
        check("rst_cnt", 32'(redirect_cnt), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        reset = 0;
        tick(); check("seq1", pc_out, 32'h3004);
        tick(); check("seq2", pc_out, 32'h3008);
        tick(); check("seq3", pc_out, 32'h300C);
        tick(); check("seq4", pc_out, 32'h3010);

        // Backward branch EQ, then NE not taken
        branch = 1; br_cond = 3'b000; cmp_a = 5; cmp_b = 5; imm16 = 16'hFFFC;
        tick(); check("beq_pc", pc_out, 32'h3004); check("beq_cnt", 32'(redirect_cnt), 32'd1);
        br_cond = 3'b001;
        tick(); check("bne_pc", pc_out, 32'h3008); check("bne_cnt", 32'(redirect_cnt), 32'd1);

        // Zero compares
        imm16 = 16'h0010;
        br_cond = 3'b011; cmp_a = 32'h8000_0000;
        tick(); check("gtz_neg", pc_out, 32'h300C);
        br_cond = 3'b010; cmp_a = 0;
        tick(); check("lez_zero", pc_out, 32'h3050);
        br_cond = 3'b101; cmp_a = 0;
        tick(); check("gez_zero", pc_out, 32'h3094);
        br_cond = 3'b100; cmp_a = 32'hFFFF_FFFF;
        tick(); check("ltz_m1", pc_out, 32'h30D8);
        br_cond = 3'b110;
        tick(); check("code110", pc_out, 32'h30DC);

        // j, then misaligned jr; addr_err stays set
        branch = 0; cmp_a = 0;
        jump = 2'b01; instr_index = 26'h0000C40;
        tick(); check("j_pc", pc_out, 32'h3100);
        jump = 2'b10; jr_target = 32'h3202;
        tick(); check("jr_pc", pc_out, 32'h3200); check("jr_err", 32'(addr_err), 32'd1);
        jump = 2'b11;
        tick(); check("jmp11_pc", pc_out, 32'h3204); check("err_sticky", 32'(addr_err), 32'd1);

        // Stall with redirect held; a later redirect during the stall is ignored
        idle_inputs();
        stall = 1; jump = 2'b01; instr_index = 26'h0000D00;
        tick(); check("hold1", pc_out, 32'h3204);
        jump = 2'b10; jr_target = 32'h5000;
        tick(); check("hold2", pc_out, 32'h3204);
        idle_inputs(); stall = 1;
        tick(); check("hold3", pc_out, 32'h3204);
        stall = 0;
        tick(); check("release_pc", pc_out, 32'h3400); check("release_cnt", 32'(redirect_cnt), 32'd7);

        // Reset while HELD clears the pending redirect
        stall = 1; jump = 2'b01; instr_index = 26'h0000D00;
        tick();
        reset = 1; jump = 0;
        tick(); check("rst_held_pc", pc_out, 32'h3000); check("rst_held_cnt", 32'(redirect_cnt), 32'd0);
        reset = 0; stall = 0;
        tick(); check("rst_held_nopend", pc_out, 32'h3004);

        // Five redirects saturate the 2-bit counter
        jump = 2'b01; instr_index = 26'h0000D00;
        for (int i = 0; i < 5; i++) tick();
        check("sat_cnt2", 32'(redirect_cnt2), 32'd3);
        check("sat_cnt16", 32'(redirect_cnt), 32'd5);

        // PC wrap at the top of the address space
        jump = 2'b10; jr_target = 32'hFFFF_FFFC;
        tick(); check("pre_wrap", pc_out, 32'hFFFF_FFFC);
        jump = 0;
        tick(); check("wrap_pc", pc_out, 32'h0000_0000);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            reset  = ($urandom_range(0, 59) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            branch = $urandom_range(0, 1);
            br_cond = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: cmp_a = 0;
                1: cmp_a = 32'hFFFF_FFFF;
                2: cmp_a = 32'h8000_0000;
                3: cmp_a = 32'($urandom_range(0, 3));
                default: cmp_a = $urandom;
            endcase
            cmp_b = ($urandom_range(0, 1) == 1) ? cmp_a : $urandom;
            imm16 = 16'($urandom);
            jump = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) jump = 2'b00;
            instr_index = 26'($urandom);
            jr_target = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
